ifft_core: RTL and testbench

IFFT_CORE -- requirements
Module: ifft_core

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_butterfly.sv | 42 ++++
 rtl/ifft_core.sv | 121 ++++++++++++
 tb/tb_ifft_core.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT/IFFT definitions: FSM states, bit-reverse addressing and the
// elaboration-time twiddle generator.
package fft_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  localparam real PI = 3.14159265358979323846;

  function automatic int unsigned bit_rev(input int unsigned v, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++) r[i] = v[bits-1-i];
    return r;
  endfunction

  // Twiddle exp(+j*2*pi*m/ns) in nb-bit signed with nb-2 fraction bits, rounded to nearest.
  function automatic int tw_re(input int m, input int ns, input int nb);
    return int'($cos(2.0 * PI * m / ns) * (2.0 ** (nb - 2)));
  endfunction

  function automatic int tw_im(input int m, input int ns, input int nb);
    return int'($sin(2.0 * PI * m / ns) * (2.0 ** (nb - 2)));
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly with per-stage 1/2 scaling: a'=(a+w*b)>>>1, b'=(a-w*b)>>>1.
module fft_butterfly #(
  parameter int NB = 10
) (
  input  logic [NB-1:0] a_re,
  input  logic [NB-1:0] a_im,
  input  logic [NB-1:0] b_re,
  input  logic [NB-1:0] b_im,
  input  logic [NB-1:0] w_re,
  input  logic [NB-1:0] w_im,
  output logic [NB-1:0] x_re,
  output logic [NB-1:0] x_im,
  output logic [NB-1:0] y_re,
  output logic [NB-1:0] y_im
);
  localparam int PW = 2 * NB;

  logic signed [PW-1:0] rr, ii, ri, ir;
  logic signed [PW:0]   p_re, p_im;
  logic signed [NB+1:0] t_re, t_im;
  logic signed [NB+2:0] s_re, s_im, d_re, d_im;

  always_comb begin
    rr   = $signed(b_re) * $signed(w_re);
    ii   = $signed(b_im) * $signed(w_im);
    ri   = $signed(b_re) * $signed(w_im);
    ir   = $signed(b_im) * $signed(w_re);
    p_re = (PW+1)'(rr) - (PW+1)'(ii);
    p_im = (PW+1)'(ri) + (PW+1)'(ir);
    // |w*b| <= sqrt(2)*2^(NB-1), so NB+2 bits hold t after dropping the twiddle fraction
    t_re = (NB+2)'(p_re >>> (NB - 2));
    t_im = (NB+2)'(p_im >>> (NB - 2));
    s_re = (NB+3)'($signed(a_re)) + (NB+3)'(t_re);
    s_im = (NB+3)'($signed(a_im)) + (NB+3)'(t_im);
    d_re = (NB+3)'($signed(a_re)) - (NB+3)'(t_re);
    d_im = (NB+3)'($signed(a_im)) - (NB+3)'(t_im);
    x_re = NB'(s_re >>> 1);
    x_im = NB'(s_im >>> 1);
    y_re = NB'(d_re >>> 1);
    y_im = NB'(d_im >>> 1);
  end
endmodule

// File: rtl/ifft_core.sv
// Streaming in-place radix-2 IFFT: load bins bit-reversed, one butterfly per
// cycle, then unload time samples in natural order with ready/valid backpressure.
module ifft_core
  import fft_pkg::*;
#(
  parameter int NB      = 10,
  parameter int LOG2_NS = 3,
  parameter int NS      = 1 << LOG2_NS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NB-1:0] in_re,
  input  logic [NB-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NB-1:0] out_re,
  output logic [NB-1:0] out_im,
  output logic          out_last,
  output logic          busy
);
  localparam int AW = LOG2_NS;

  if (NS != (1 << LOG2_NS) || LOG2_NS < 3 || LOG2_NS > 6) begin : g_bad_size
    $error("ifft_core: NS must equal 1<<LOG2_NS with LOG2_NS in 3..6");
  end

  state_t         state, state_nx;
  logic [AW-1:0]  cnt;
  logic [2:0]     stage;
  logic [AW-2:0]  bfly;
  logic           last_bfly;

  logic [NB-1:0]  mem_re [NS];
  logic [NB-1:0]  mem_im [NS];
  logic [NB-1:0]  tw_re_t [NS/2];
  logic [NB-1:0]  tw_im_t [NS/2];

  logic [AW-1:0]  wr_addr, half, pos_mask, pos, top, bot;
  logic [AW-2:0]  tw_idx;
  logic [NB-1:0]  x_re, x_im, y_re, y_im;

  for (genvar m = 0; m < NS/2; m++) begin : g_tw
    localparam int TR = tw_re(m, NS, NB);
    localparam int TI = tw_im(m, NS, NB);
    assign tw_re_t[m] = NB'(TR);
    assign tw_im_t[m] = NB'(TI);
  end

  // Butterfly j of stage s pairs top=group*2^(s+1)+pos with bot=top+2^s, twiddle pos*NS/2^(s+1).
  always_comb begin
    wr_addr   = AW'(bit_rev(32'(cnt), 32'(LOG2_NS)));
    half      = AW'(1) << stage;
    pos_mask  = half - 1'b1;
    pos       = AW'(bfly) & pos_mask;
    top       = ((AW'(bfly) & ~pos_mask) << 1) | pos;
    bot       = top | half;
    tw_idx    = (AW-1)'(pos << (3'(LOG2_NS - 1) - stage));
    last_bfly = (&bfly) && (stage == 3'(LOG2_NS - 1));
  end

  fft_butterfly #(.NB(NB)) u_bfly (
    .a_re(mem_re[top]), .a_im(mem_im[top]),
    .b_re(mem_re[bot]), .b_im(mem_im[bot]),
    .w_re(tw_re_t[tw_idx]), .w_im(tw_im_t[tw_idx]),
    .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im)
  );

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (in_valid && cnt == AW'(NS - 1)) state_nx = COMPUTE;
      COMPUTE: if (last_bfly) state_nx = UNLOAD;
      UNLOAD:  if (out_ready && cnt == AW'(NS - 1)) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= '0;
      stage <= '0;
      bfly  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        LOAD:    if (in_valid) cnt <= cnt + 1'b1;
        COMPUTE: begin
          bfly <= bfly + 1'b1;
          if (&bfly) stage <= last_bfly ? 3'd0 : stage + 3'd1;
        end
        UNLOAD:  if (out_ready) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Sample memory is not reset; an aborted frame is simply overwritten by the next load.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      mem_re[wr_addr] <= in_re;
      mem_im[wr_addr] <= in_im;
    end else if (state == COMPUTE) begin
      mem_re[top] <= x_re;
      mem_im[top] <= x_im;
      mem_re[bot] <= y_re;
      mem_im[bot] <= y_im;
    end
  end

  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == UNLOAD);
    busy      = (state != LOAD);
    out_last  = out_valid && (cnt == AW'(NS - 1));
    out_re    = out_valid ? mem_re[cnt] : '0;
    out_im    = out_valid ? mem_im[cnt] : '0;
  end
endmodule

// File: tb/tb_ifft_core.sv
// Bench for ifft_core: directed impulse table, latency/stall/abort sequences on an
// NS=8 core, and random frames for LOG2_NS=3..6 checked against a float inverse DFT.
module tb_ifft_core;
  localparam real PI = 3.14159265358979323846;

  logic clk = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  int last_hs = 0, first_valid = 0;

  logic rst_n, rst_g, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [9:0] in_re, in_im, out_re, out_im;

  ifft_core #(.NB(10), .LOG2_NS(3), .NS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_last(out_last), .busy(busy)
  );

  task automatic chk(input string name, input int act, input real exp, input real tol);
    real d;
    checks++;
    d = real'(act) - exp;
    if (d > tol || d < -tol) begin
      errors++;
      $display("FAIL %s: got %0d, want %0.2f (+/-%0.1f)", name, act, exp, tol);
    end
  endtask

  function automatic int sv(input logic [9:0] v);
    return int'($signed(v));
  endfunction

  // x[n] = (1/ns) * sum_k X[k] * exp(+j*2*pi*k*n/ns)
  function automatic void idft(input int ns, input int xr[64], input int xi[64], input int n,
                               output real rr, output real ri);
    real th;
    rr = 0.0; ri = 0.0;
    for (int k = 0; k < ns; k++) begin
      th = 2.0 * PI * real'(k * n) / real'(ns);
      rr += xr[k] * $cos(th) - xi[k] * $sin(th);
      ri += xr[k] * $sin(th) + xi[k] * $cos(th);
    end
    rr = rr / ns;
    ri = ri / ns;
  endfunction

  task automatic send8(input int ar[64], input int ai[64], input bit gaps);
    int k = 0, bud = 0;
    while (k < 8 && bud < 200) begin
      @(negedge clk);
      bud++;
      in_valid = 0;
      if (!gaps || $urandom_range(0, 2) != 0) begin
        in_valid = 1; in_re = 10'(ar[k]); in_im = 10'(ai[k]);
        #1;
        if (in_ready) begin last_hs = cyc; k++; end
      end
    end
    if (k < 8) chk("send_timeout", k, 8, 0);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic recv8(output int orr[8], output int oii[8], input bit rnd);
    int n = 0, bud = 0, pr = 0, pim = 0;
    bit stalled = 0, seen = 0;
    while (n < 8 && bud < 300) begin
      @(negedge clk);
      bud++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        if (!seen) begin seen = 1; first_valid = cyc; end
        chk("in_ready_unload", int'(in_ready), 0, 0);
        if (stalled) begin
          chk("stall_re", sv(out_re), pr, 0);
          chk("stall_im", sv(out_im), pim, 0);
        end
        if (out_ready) begin
          orr[n] = sv(out_re); oii[n] = sv(out_im);
          chk("out_last", int'(out_last), (n == 7) ? 1 : 0, 0);
          n++; stalled = 0;
        end else begin
          stalled = 1; pr = sv(out_re); pim = sv(out_im);
        end
      end else if (!seen) begin
        chk("busy_compute", int'(busy), 1, 0);
      end
    end
    if (n < 8) chk("recv_timeout", n, 8, 0);
    @(negedge clk);
    out_ready = 0;
  endtask

  for (genvar g = 0; g < 4; g++) begin : gs
    localparam int L = 3 + g;
    localparam int N = 1 << L;
    logic iv, ir, ov, ordy, ol, bz;
    logic [9:0] ire, iim, ore, oim;
    bit done = 0;

    ifft_core #(.NB(10), .LOG2_NS(L), .NS(N)) dut_r (
      .clk(clk), .rst_n(rst_g), .in_valid(iv), .in_ready(ir),
      .in_re(ire), .in_im(iim), .out_valid(ov), .out_ready(ordy),
      .out_re(ore), .out_im(oim), .out_last(ol), .busy(bz)
    );

    initial begin : run
      int br[64], bi[64];
      int k, n, bud, pr, pim;
      bit stl;
      real rr, ri;
      iv = 0; ire = 0; iim = 0; ordy = 0;
      br = '{default: 0}; bi = '{default: 0};
      while (!rst_g) @(negedge clk);
      for (int f = 0; f < 5; f++) begin
        for (int i = 0; i < N; i++) begin
          br[i] = int'($urandom_range(0, 1022)) - 511;
          bi[i] = int'($urandom_range(0, 1022)) - 511;
        end
        k = 0; bud = 0;
        while (k < N && bud < 1000) begin
          @(negedge clk);
          bud++;
          iv = 1; ire = 10'(br[k]); iim = 10'(bi[k]);
          #1;
          if (ir) k++;
        end
        if (k < N) chk($sformatf("rand_L%0d_send_timeout", L), k, N, 0);
        @(negedge clk);
        iv = 0;
        n = 0; bud = 0; stl = 0; pr = 0; pim = 0;
        while (n < N && bud < 2000) begin
          @(negedge clk);
          bud++;
          ordy = 1'($urandom_range(0, 1));
          if (ov) begin
            if (stl) begin
              chk($sformatf("rand_L%0d_stall_re", L), sv(ore), pr, 0);
              chk($sformatf("rand_L%0d_stall_im", L), sv(oim), pim, 0);
            end
            if (ordy) begin
              idft(N, br, bi, n, rr, ri);
              chk($sformatf("rand_L%0d_f%0d_re%0d", L, f, n), sv(ore), rr, L + 1);
              chk($sformatf("rand_L%0d_f%0d_im%0d", L, f, n), sv(oim), ri, L + 1);
              chk($sformatf("rand_L%0d_last", L), int'(ol), (n == N - 1) ? 1 : 0, 0);
              n++; stl = 0;
            end else begin
              stl = 1; pr = sv(ore); pim = sv(oim);
            end
          end
        end
        if (n < N) chk($sformatf("rand_L%0d_recv_timeout", L), n, N, 0);
        @(negedge clk);
        ordy = 0;
      end
      done = 1;
    end
  end

  typedef struct {
    int bin;
    int tol;
    int er[8];
    int ei[8];
  } vec_t;

  initial begin
    vec_t tv[3];
    int ar[64], ai[64];
    int gr[8], gi[8];
    int t;

    rst_n = 0; rst_g = 0; in_valid = 0; in_re = 0; in_im = 0; out_ready = 0;
    tv[0].bin = 0; tv[0].tol = 1;
    tv[0].er = '{32, 32, 32, 32, 32, 32, 32, 32};
    tv[0].ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    tv[1].bin = 1; tv[1].tol = 4;
    tv[1].er = '{32, 23, 0, -23, -32, -23, 0, 23};
    tv[1].ei = '{0, 23, 32, 23, 0, -23, -32, -23};
    tv[2].bin = 2; tv[2].tol = 4;
    tv[2].er = '{32, 0, -32, 0, 32, 0, -32, 0};
    tv[2].ei = '{0, 32, 0, -32, 0, 32, 0, -32};

    repeat (3) @(negedge clk);
    rst_n = 1; rst_g = 1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_out_last", int'(out_last), 0, 0);
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_out_re", sv(out_re), 0, 0);
    chk("rst_out_im", sv(out_im), 0, 0);

    for (int v = 0; v < 3; v++) begin
      ar = '{default: 0}; ai = '{default: 0};
      ar[tv[v].bin] = 256;
      send8(ar, ai, v == 2);
      recv8(gr, gi, v == 1);
      chk($sformatf("v%0d_latency", v), first_valid - last_hs, 13, 0);
      for (int n = 0; n < 8; n++) begin
        chk($sformatf("v%0d_re%0d", v, n), gr[n], tv[v].er[n], tv[v].tol);
        chk($sformatf("v%0d_im%0d", v, n), gi[n], tv[v].ei[n], tv[v].tol);
      end
    end

    // Abort a bin-1 frame mid-COMPUTE; the following bin-0 frame must come out alone.
    ar = '{default: 0}; ai = '{default: 0};
    ar[1] = 256;
    send8(ar, ai, 0);
    repeat (4) @(negedge clk);
    chk("abort_busy_before", int'(busy), 1, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("abort_in_ready", int'(in_ready), 1, 0);
    chk("abort_busy", int'(busy), 0, 0);
    chk("abort_out_valid", int'(out_valid), 0, 0);
    ar[1] = 0; ar[0] = 256;
    send8(ar, ai, 0);
    recv8(gr, gi, 1);
    chk("abort_latency", first_valid - last_hs, 13, 0);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("abort_re%0d", n), gr[n], tv[0].er[n], tv[0].tol);
      chk($sformatf("abort_im%0d", n), gi[n], tv[0].ei[n], tv[0].tol);
    end

    t = 0;
    while (!(gs[0].done && gs[1].done && gs[2].done && gs[3].done) && t < 30000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 30000) chk("random_frames_timeout", t, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
